// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, constants and operand unpacking for the fp32 arithmetic blocks
// (adder, multiplier, random source).
package fp32_pkg;

  localparam int unsigned SIGN_W   = 1;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_BIAS = 127;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP32_ONE     = 32'h3F800000;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp32_unpacked_t;

  // Denormals (exp == 0) classify as zero; the arithmetic blocks flush them.
  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.mant    = x[22:0];
    u.is_zero = (x[30:23] == '0);
    u.is_inf  = (x[30:23] == '1) && (x[22:0] == '0);
    u.is_nan  = (x[30:23] == '1) && (x[22:0] != '0);
    return u;
  endfunction

endpackage

// File: rtl/fp32_pipelined_adder_if.sv
// Operand/result bundle of the pipelined fp32 adder; valid-only handshake, no backpressure.
interface fp32_pipelined_adder_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] inA;
  logic [DATA_WIDTH-1:0] inB;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output valid_in, inA, inB,
    input  valid_out, out_data
  );

  modport slave (
    input  valid_in, inA, inB,
    output valid_out, out_data
  );

endinterface

// File: rtl/fp32_lzc27.sv
// Combinational leading-zero counter for the 27-bit extended mantissa; all-zero input yields 27.
module fp32_lzc27 (
  input  logic [26:0] val_i,
  output logic [4:0]  cnt_o
);

  always_comb begin
    cnt_o = 5'd27;
    // Ascending scan so the most significant set bit wins.
    for (int unsigned i = 0; i < 27; i++) begin
      if (val_i[i]) cnt_o = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp32_pipelined_adder.sv
// Seven-stage IEEE-754 binary32 adder, one result per clock. Denormals flush to zero,
// rounding is nearest-even, and specials bypass the datapath alongside the valid pipeline.
module fp32_pipelined_adder
  import fp32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 7
) (
  input logic                   clk,
  input logic                   rstn,
  fp32_pipelined_adder_if.slave bus
);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             spec;
    logic [31:0]      spec_val;
  } ctl_t;

  logic [LATENCY-1:0]    vld_q;
  logic [DATA_WIDTH-1:0] out_q, out_d;

  ctl_t ctl_q [1:5];

  // Stage 1: unpack, classify, order by magnitude
  fp32_unpacked_t   ua, ub, hi, lo;
  logic [30:0]      mag_a, mag_b;
  ctl_t             s1_ctl_d;
  logic             s1_sub_d, s1_sub_q;
  logic [EXP_W-1:0] s1_exps_d, s1_exps_q;
  logic [MANT_W:0]  s1_mb_d, s1_mb_q, s1_ms_d, s1_ms_q;

  always_comb begin
    ua    = fp32_unpack(bus.inA);
    ub    = fp32_unpack(bus.inB);
    mag_a = ua.is_zero ? '0 : {ua.exp, ua.mant};
    mag_b = ub.is_zero ? '0 : {ub.exp, ub.mant};
    if (mag_b > mag_a) begin
      hi = ub;
      lo = ua;
    end else begin
      hi = ua;
      lo = ub;
    end
    s1_ctl_d.sign     = hi.sign;
    s1_ctl_d.exp      = hi.exp;
    s1_ctl_d.spec     = 1'b1;
    s1_ctl_d.spec_val = '0;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)))
      s1_ctl_d.spec_val = FP32_QNAN;
    else if (ua.is_inf)
      s1_ctl_d.spec_val = {ua.sign, FP32_POS_INF[30:0]};
    else if (ub.is_inf)
      s1_ctl_d.spec_val = {ub.sign, FP32_POS_INF[30:0]};
    else if (ua.is_zero && ub.is_zero)
      s1_ctl_d.spec_val = {ua.sign & ub.sign, 31'b0};
    else
      s1_ctl_d.spec = 1'b0;
    s1_sub_d  = ua.sign != ub.sign;
    s1_exps_d = lo.exp;
    s1_mb_d   = hi.is_zero ? '0 : {1'b1, hi.mant};
    s1_ms_d   = lo.is_zero ? '0 : {1'b1, lo.mant};
  end

  // Stage 2: exponent difference
  logic             s2_sub_q;
  logic [EXP_W-1:0] s2_diff_q;
  logic [MANT_W:0]  s2_mb_q, s2_ms_q;

  // Stage 3: align the smaller operand; bits shifted out collapse into sticky
  logic [53:0] s3_sh;
  logic [26:0] s3_exts_d, s3_exts_q, s3_extb_q;
  logic        s3_sub_q;

  always_comb begin
    s3_sh = {s2_ms_q, 30'b0} >> s2_diff_q;
    if (s2_diff_q >= 8'd26)
      s3_exts_d = {26'b0, |s2_ms_q};
    else
      s3_exts_d = {s3_sh[53:28], s3_sh[27] | (|s3_sh[26:0])};
  end

  // Stage 4: magnitude add/subtract; |hi| >= |lo| keeps the difference non-negative
  logic [27:0] s4_sum_d, s4_sum_q;

  always_comb begin
    if (s3_sub_q)
      s4_sum_d = {1'b0, s3_extb_q} - {1'b0, s3_exts_q};
    else
      s4_sum_d = {1'b0, s3_extb_q} + {1'b0, s3_exts_q};
  end

  // Stage 5: leading-zero count
  logic [4:0]  s5_lz_d, s5_lz_q;
  logic [27:0] s5_sum_q;

  fp32_lzc27 u_lzc (
    .val_i (s4_sum_q[26:0]),
    .cnt_o (s5_lz_d)
  );

  // Stage 6: normalize; exponent kept signed and wide to catch underflow
  logic [26:0]       s6_mant_d, s6_mant_q;
  logic signed [9:0] s6_exp_d, s6_exp_q;
  logic              s6_zero_d, s6_zero_q;
  logic              s6_sign_q, s6_spec_q;
  logic [31:0]       s6_spec_val_q;

  always_comb begin
    if (s5_sum_q[27]) begin
      s6_mant_d = {s5_sum_q[27:2], s5_sum_q[1] | s5_sum_q[0]};
      s6_exp_d  = signed'({2'b00, ctl_q[5].exp}) + 10'sd1;
    end else begin
      s6_mant_d = s5_sum_q[26:0] << s5_lz_q;
      s6_exp_d  = signed'({2'b00, ctl_q[5].exp}) - signed'({5'b0, s5_lz_q});
    end
    s6_zero_d = (s5_sum_q == '0) || (s6_exp_d < 10'sd1);
  end

  // Stage 7: round to nearest even, pack
  logic              s7_rnd;
  logic [24:0]       s7_m25;
  logic signed [9:0] s7_exp;

  always_comb begin
    s7_rnd = s6_mant_q[2] & (s6_mant_q[1] | s6_mant_q[0] | s6_mant_q[3]);
    s7_m25 = {1'b0, s6_mant_q[26:3]} + {24'b0, s7_rnd};
    s7_exp = s6_exp_q + (s7_m25[24] ? 10'sd1 : 10'sd0);
    if (s6_spec_q)
      out_d = s6_spec_val_q;
    else if (s6_zero_q)
      out_d = '0;
    else if (s7_exp >= 10'sd255)
      out_d = {s6_sign_q, FP32_POS_INF[30:0]};
    else
      out_d = {s6_sign_q, s7_exp[7:0], s7_m25[24] ? s7_m25[23:1] : s7_m25[22:0]};
  end

  always_ff @(posedge clk) begin
    ctl_q[1]  <= s1_ctl_d;
    s1_sub_q  <= s1_sub_d;
    s1_exps_q <= s1_exps_d;
    s1_mb_q   <= s1_mb_d;
    s1_ms_q   <= s1_ms_d;
    for (int unsigned k = 2; k <= 5; k++) ctl_q[k] <= ctl_q[k-1];

    s2_diff_q <= ctl_q[1].exp - s1_exps_q;
    s2_sub_q  <= s1_sub_q;
    s2_mb_q   <= s1_mb_q;
    s2_ms_q   <= s1_ms_q;

    s3_extb_q <= {s2_mb_q, 3'b000};
    s3_exts_q <= s3_exts_d;
    s3_sub_q  <= s2_sub_q;

    s4_sum_q  <= s4_sum_d;

    s5_sum_q  <= s4_sum_q;
    s5_lz_q   <= s5_lz_d;

    s6_mant_q     <= s6_mant_d;
    s6_exp_q      <= s6_exp_d;
    s6_zero_q     <= s6_zero_d;
    s6_sign_q     <= ctl_q[5].sign;
    s6_spec_q     <= ctl_q[5].spec;
    s6_spec_val_q <= ctl_q[5].spec_val;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      vld_q <= '0;
      out_q <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], bus.valid_in};
      if (vld_q[LATENCY-2]) out_q <= out_d;
    end
  end

  assign bus.valid_out = vld_q[LATENCY-1];
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_fp32_pipelined_adder.sv
// Scoreboard bench for fp32_pipelined_adder: expected sums are queued at issue and checked,
// together with the 7-cycle latency, when valid_out appears.
module tb_fp32_pipelined_adder;

  logic        clk = 1'b0;
  logic        rstn;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] val;
    logic [31:0] mask;
    int unsigned t;
    string       nm;
  } exp_t;

  exp_t sb [$];

  fp32_pipelined_adder_if #(.DATA_WIDTH(32)) bus ();

  fp32_pipelined_adder #(.DATA_WIDTH(32), .LATENCY(7)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] v,
                       input logic [31:0] m, input string nm);
    exp_t e;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.inA      = a;
    bus.inB      = b;
    e.val = v; e.mask = m; e.t = cyc; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.inA      = '0;
      bus.inB      = '0;
    end
  endtask

  task automatic test_reset();
    rstn         = 1'b1;
    bus.valid_in = 1'b1;
    bus.inA      = 32'h3F800000;
    bus.inB      = 32'h3F800000;
    repeat (9) @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: valid_out=%b out_data=%h, required 0 00000000", bus.valid_out, bus.out_data);
    end
    rstn         = 1'b0;
    bus.valid_in = 1'b0;
    repeat (8) begin
      @(negedge clk);
      total++;
      if (bus.valid_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_release: valid_out=%b, required 0", bus.valid_out);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    fork
      begin
        issue(32'h3F800000, 32'h3F800000, 32'h40000000, '1, "sum_1_1");
        issue(32'h3FC00000, 32'h3E800000, 32'h3FE00000, '1, "sum_1p5_0p25");
        issue(32'h3F800000, 32'hC0000000, 32'hBF800000, '1, "sum_1_m2");
        issue(32'h40400000, 32'hBF800000, 32'h40000000, '1, "sum_3_m1");
        issue(32'h3F000000, 32'hBF400000, 32'hBE800000, '1, "sum_0p5_m0p75");
        issue(32'h3F800000, 32'hBF800000, 32'h00000000, '1, "cancel_1");
        issue(32'h40490FDB, 32'hC0490FDB, 32'h00000000, '1, "cancel_pi");
        issue(32'h3C23D70A, 32'hBF7F3B64, 32'h80000000, 32'h80000000, "cmp_less");
        issue(32'hBF7F3B64, 32'h3C23D70A, 32'h80000000, 32'h80000000, "cmp_less_swapped");
        issue(32'h3F7F3B64, 32'hBC23D70A, 32'h00000000, 32'h80000000, "cmp_greater");
        idle(1);
      end
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.valid_out === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL basic_spurious: valid_out=1 at cycle %0d, required 0", cyc);
          end else begin
            e = sb.pop_front();
            if ((((bus.out_data ^ e.val) & e.mask) !== 32'h0) || ((cyc - e.t) != 7)) begin
              bad++;
              $display("FAIL %s: out_data=%h latency=%0d, required %h (mask %h) latency=7",
                       e.nm, bus.out_data, cyc - e.t, e.val, e.mask);
            end
          end
        end
      end
    join
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL basic_missing: outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_rounding();
    exp_t e;
    fork
      begin
        issue(32'h3F800000, 32'h33800000, 32'h3F800000, '1, "tie_even_down");
        issue(32'h3F800001, 32'h33800000, 32'h3F800002, '1, "tie_odd_up");
        issue(32'h3F800000, 32'h33800001, 32'h3F800001, '1, "above_tie_up");
        issue(32'h3F800000, 32'h34400000, 32'h3F800002, '1, "round_up_1p5ulp");
        issue(32'h3FFFFFFF, 32'h33800000, 32'h40000000, '1, "round_carry_exp");
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, '1, "overflow_pos");
        issue(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, '1, "overflow_neg");
        issue(32'h00800001, 32'h80800000, 32'h00000000, '1, "underflow_flush");
        idle(1);
      end
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.valid_out === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL round_spurious: valid_out=1 at cycle %0d, required 0", cyc);
          end else begin
            e = sb.pop_front();
            if ((((bus.out_data ^ e.val) & e.mask) !== 32'h0) || ((cyc - e.t) != 7)) begin
              bad++;
              $display("FAIL %s: out_data=%h latency=%0d, required %h latency=7",
                       e.nm, bus.out_data, cyc - e.t, e.val);
            end
          end
        end
      end
    join
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL round_missing: outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_specials();
    exp_t e;
    fork
      begin
        issue(32'h7F800000, 32'hFF800000, 32'h7FC00000, '1, "inf_minus_inf");
        issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, '1, "nan_a");
        issue(32'h3F800000, 32'hFFC00000, 32'h7FC00000, '1, "nan_b");
        issue(32'h7F800000, 32'hC0000000, 32'h7F800000, '1, "inf_plus_finite");
        issue(32'h40000000, 32'hFF800000, 32'hFF800000, '1, "finite_plus_ninf");
        issue(32'hFF800000, 32'hFF800000, 32'hFF800000, '1, "ninf_plus_ninf");
        issue(32'h00400000, 32'h00000000, 32'h00000000, '1, "denorm_plus_zero");
        issue(32'h3F800000, 32'h00000001, 32'h3F800000, '1, "one_plus_denorm");
        issue(32'h80000000, 32'h80000000, 32'h80000000, '1, "negzero_negzero");
        issue(32'h00000000, 32'h80000000, 32'h00000000, '1, "zero_negzero");
        issue(32'h3F800000, 32'h80000000, 32'h3F800000, '1, "one_plus_negzero");
        idle(1);
      end
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.valid_out === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL special_spurious: valid_out=1 at cycle %0d, required 0", cyc);
          end else begin
            e = sb.pop_front();
            if ((((bus.out_data ^ e.val) & e.mask) !== 32'h0) || ((cyc - e.t) != 7)) begin
              bad++;
              $display("FAIL %s: out_data=%h latency=%0d, required %h latency=7",
                       e.nm, bus.out_data, cyc - e.t, e.val);
            end
          end
        end
      end
    join
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL special_missing: outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    fork
      begin
        issue(32'h3F800000, 32'h3F800000, 32'h40000000, '1, "b2b_0");
        issue(32'h3FC00000, 32'h3E800000, 32'h3FE00000, '1, "b2b_1");
        issue(32'h3F800000, 32'hC0000000, 32'hBF800000, '1, "b2b_2");
        idle(2);
        issue(32'h40000000, 32'h40000000, 32'h40800000, '1, "b2b_after_gap_0");
        issue(32'h3F800000, 32'hBF800000, 32'h00000000, '1, "b2b_after_gap_1");
        idle(1);
      end
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.valid_out === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL b2b_spurious: valid_out=1 at cycle %0d, required 0", cyc);
          end else begin
            e = sb.pop_front();
            if ((((bus.out_data ^ e.val) & e.mask) !== 32'h0) || ((cyc - e.t) != 7)) begin
              bad++;
              $display("FAIL %s: out_data=%h latency=%0d, required %h latency=7",
                       e.nm, bus.out_data, cyc - e.t, e.val);
            end
          end
        end
      end
    join
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing: outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midflight();
    issue(32'h3F800000, 32'h3F800000, 32'h40000000, '1, "flush_0");
    issue(32'h3FC00000, 32'h3E800000, 32'h3FE00000, '1, "flush_1");
    idle(1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    sb.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.valid_out !== 1'b0 || bus.out_data !== 32'h0) begin
        bad++;
        $display("FAIL midflight_flush: cycle %0d valid_out=%b out_data=%h, required 0 00000000",
                 c, bus.valid_out, bus.out_data);
      end
    end
  endtask

  initial begin
    rstn         = 1'b1;
    bus.valid_in = 1'b0;
    bus.inA      = '0;
    bus.inB      = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
